// File: rtl/cicero_host_ctrl.sv
// Host command sequencer between the JTAG register bank and the CICERO core.
// Runs write, read-back, engine run with timeout, and engine reset sequences.
module cicero_host_ctrl #(
  parameter int MEM_ADDR_W     = 10,
  parameter int RD_LATENCY     = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           command,
  input  logic [31:0]           address,
  input  logic [31:0]           start_cc_pointer,
  input  logic [31:0]           end_cc_pointer,
  input  logic [63:0]           data_in,
  output logic [63:0]           data_out,
  output logic [31:0]           status,
  output logic                  mem_we,
  output logic                  mem_rd_en,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [63:0]           mem_wdata,
  input  logic [63:0]           mem_rdata,
  output logic                  eng_rst,
  output logic                  eng_start,
  output logic [31:0]           eng_start_cc,
  output logic [31:0]           eng_end_cc,
  input  logic                  eng_done,
  input  logic                  eng_accept
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WRITE     = 3'd1;
  localparam logic [2:0] S_READ      = 3'd2;
  localparam logic [2:0] S_RUN_START = 3'd3;
  localparam logic [2:0] S_RUN_WAIT  = 3'd4;
  localparam logic [2:0] S_ENG_RST   = 3'd5;
  localparam logic [2:0] S_ERROR     = 3'd6;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;
  localparam logic [7:0] OP_RUN   = 8'h03;
  localparam logic [7:0] OP_ERST  = 8'h04;
  localparam logic [7:0] OP_CLR   = 8'h05;

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]  RD_LAT  = 3'(RD_LATENCY);

  logic [2:0]            r_state,        w_state;
  logic [31:0]           r_last_cmd,     w_last_cmd;
  logic [2:0]            r_rd_cnt,       w_rd_cnt;
  logic [31:0]           r_to_cnt,       w_to_cnt;
  logic [1:0]            r_rst_cnt,      w_rst_cnt;
  logic                  r_err,          w_err;
  logic [1:0]            r_err_code,     w_err_code;
  logic                  r_last_acc,     w_last_acc;
  logic [7:0]            r_last_op,      w_last_op;
  logic [15:0]           r_last_tag,     w_last_tag;
  logic [63:0]           r_data_out,     w_data_out;
  logic [MEM_ADDR_W-1:0] r_mem_addr,     w_mem_addr;
  logic [63:0]           r_mem_wdata,    w_mem_wdata;
  logic [31:0]           r_eng_start_cc, w_eng_start_cc;
  logic [31:0]           r_eng_end_cc,   w_eng_end_cc;
  logic                  r_mem_we, r_mem_rd_en, r_eng_rst, r_eng_start;
  logic [31:0]           r_status;

  logic       w_new;
  logic [7:0] w_op;
  logic       w_busy;
  logic       w_unused_addr;

  assign w_new         = (command != r_last_cmd);
  assign w_op          = command[7:0];
  assign w_unused_addr = ^address[31:MEM_ADDR_W];

  always_comb begin
    w_state        = r_state;
    w_last_cmd     = r_last_cmd;
    w_rd_cnt       = r_rd_cnt;
    w_to_cnt       = r_to_cnt;
    w_rst_cnt      = r_rst_cnt;
    w_err          = r_err;
    w_err_code     = r_err_code;
    w_last_acc     = r_last_acc;
    w_last_op      = r_last_op;
    w_last_tag     = r_last_tag;
    w_data_out     = r_data_out;
    w_mem_addr     = r_mem_addr;
    w_mem_wdata    = r_mem_wdata;
    w_eng_start_cc = r_eng_start_cc;
    w_eng_end_cc   = r_eng_end_cc;
    case (r_state)
      S_IDLE: begin
        if (w_new) begin
          w_last_cmd = command;
          w_last_op  = w_op;
          w_last_tag = command[23:8];
          case (w_op)
            OP_NOP: ;
            OP_WRITE: begin
              w_mem_addr  = address[MEM_ADDR_W-1:0];
              w_mem_wdata = data_in;
              w_state     = S_WRITE;
            end
            OP_READ: begin
              w_mem_addr = address[MEM_ADDR_W-1:0];
              w_rd_cnt   = RD_LAT;
              w_state    = S_READ;
            end
            OP_RUN: begin
              // An inverted pointer range never reaches the engine.
              if (start_cc_pointer > end_cc_pointer) begin
                w_err      = 1'b1;
                w_err_code = 2'd3;
                w_state    = S_ERROR;
              end else begin
                w_eng_start_cc = start_cc_pointer;
                w_eng_end_cc   = end_cc_pointer;
                w_state        = S_RUN_START;
              end
            end
            OP_ERST: begin
              w_rst_cnt = 2'd0;
              w_state   = S_ENG_RST;
            end
            OP_CLR: begin
              w_err      = 1'b0;
              w_err_code = 2'd0;
            end
            default: begin
              w_err      = 1'b1;
              w_err_code = 2'd1;
              w_state    = S_ERROR;
            end
          endcase
        end
      end
      S_WRITE: w_state = S_IDLE;
      S_READ: begin
        if (r_rd_cnt == 3'd0) begin
          w_data_out = mem_rdata;
          w_state    = S_IDLE;
        end else begin
          w_rd_cnt = r_rd_cnt - 3'd1;
        end
      end
      S_RUN_START: begin
        w_to_cnt = 32'd0;
        w_state  = S_RUN_WAIT;
      end
      S_RUN_WAIT: begin
        // Completion takes priority over a timeout landing in the same cycle.
        if (eng_done) begin
          w_data_out = {62'b0, 1'b1, eng_accept};
          w_last_acc = eng_accept;
          w_state    = S_IDLE;
        end else if (r_to_cnt == TO_LAST) begin
          w_err      = 1'b1;
          w_err_code = 2'd2;
          w_state    = S_ERROR;
        end else begin
          w_to_cnt = r_to_cnt + 32'd1;
        end
      end
      S_ENG_RST: begin
        if (r_rst_cnt == 2'd3) w_state = S_IDLE;
        else                   w_rst_cnt = r_rst_cnt + 2'd1;
      end
      S_ERROR: begin
        if (w_new) begin
          w_last_cmd = command;
          if (w_op == OP_CLR) begin
            w_last_op  = w_op;
            w_last_tag = command[23:8];
            w_err      = 1'b0;
            w_err_code = 2'd0;
            w_state    = S_IDLE;
          end
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign w_busy = (w_state != S_IDLE) && (w_state != S_ERROR);

  // Strobes and status are derived from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_last_cmd     <= 32'd0;
      r_rd_cnt       <= 3'd0;
      r_to_cnt       <= 32'd0;
      r_rst_cnt      <= 2'd0;
      r_err          <= 1'b0;
      r_err_code     <= 2'd0;
      r_last_acc     <= 1'b0;
      r_last_op      <= 8'd0;
      r_last_tag     <= 16'd0;
      r_data_out     <= 64'd0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= 64'd0;
      r_eng_start_cc <= 32'd0;
      r_eng_end_cc   <= 32'd0;
      r_mem_we       <= 1'b0;
      r_mem_rd_en    <= 1'b0;
      r_eng_rst      <= 1'b0;
      r_eng_start    <= 1'b0;
      r_status       <= 32'd0;
    end else begin
      r_state        <= w_state;
      r_last_cmd     <= w_last_cmd;
      r_rd_cnt       <= w_rd_cnt;
      r_to_cnt       <= w_to_cnt;
      r_rst_cnt      <= w_rst_cnt;
      r_err          <= w_err;
      r_err_code     <= w_err_code;
      r_last_acc     <= w_last_acc;
      r_last_op      <= w_last_op;
      r_last_tag     <= w_last_tag;
      r_data_out     <= w_data_out;
      r_mem_addr     <= w_mem_addr;
      r_mem_wdata    <= w_mem_wdata;
      r_eng_start_cc <= w_eng_start_cc;
      r_eng_end_cc   <= w_eng_end_cc;
      r_mem_we       <= (w_state == S_WRITE);
      r_mem_rd_en    <= (r_state != S_READ) && (w_state == S_READ);
      r_eng_rst      <= (w_state == S_ENG_RST);
      r_eng_start    <= (w_state == S_RUN_START);
      r_status       <= {w_last_tag, w_last_op, w_last_acc, w_err_code, w_err, w_busy, w_state};
    end
  end

  assign data_out     = r_data_out;
  assign status       = r_status;
  assign mem_we       = r_mem_we;
  assign mem_rd_en    = r_mem_rd_en;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign eng_rst      = r_eng_rst;
  assign eng_start    = r_eng_start;
  assign eng_start_cc = r_eng_start_cc;
  assign eng_end_cc   = r_eng_end_cc;

endmodule

// File: tb/tb_cicero_host_ctrl.sv
// Bench for cicero_host_ctrl: directed scenarios plus randomized commands
// checked against a command-level reference model with memory and engine models.
module tb_cicero_host_ctrl;
  localparam int AW  = 10;
  localparam int RDL = 2;
  localparam int TO  = 100;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   command, address, start_cc_pointer, end_cc_pointer;
  logic [63:0]   data_in, data_out;
  logic [31:0]   status;
  logic          mem_we, mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [63:0]   mem_wdata, mem_rdata;
  logic          eng_rst, eng_start;
  logic [31:0]   eng_start_cc, eng_end_cc;
  logic          eng_done = 1'b0;
  logic          eng_accept = 1'b0;

  always #5 clk = ~clk;

  cicero_host_ctrl #(.MEM_ADDR_W(AW), .RD_LATENCY(RDL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .command(command), .address(address),
    .start_cc_pointer(start_cc_pointer), .end_cc_pointer(end_cc_pointer),
    .data_in(data_in), .data_out(data_out), .status(status),
    .mem_we(mem_we), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .eng_rst(eng_rst),
    .eng_start(eng_start), .eng_start_cc(eng_start_cc), .eng_end_cc(eng_end_cc),
    .eng_done(eng_done), .eng_accept(eng_accept));

  // Memory device: data valid exactly RDL cycles after the read strobe, noise otherwise.
  logic [63:0] dev_mem [0:1023];
  logic [63:0] rd_pipe [0:RDL-1];
  always @(posedge clk) begin
    if (mem_we) dev_mem[mem_addr] <= mem_wdata;
    rd_pipe[0] <= mem_rd_en ? dev_mem[mem_addr] : {$urandom, $urandom};
    for (int i = 1; i < RDL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[RDL-1];

  // Engine: done appears in the eng_delay-th controller wait cycle (0-based), held until next start.
  int   eng_delay = 0;
  logic eng_acc_val = 1'b0;
  int   eng_cnt = 0;
  logic eng_armed = 1'b0;
  always @(posedge clk) begin
    if (eng_start) begin
      eng_done <= 1'b0; eng_accept <= 1'b0; eng_cnt <= 0; eng_armed <= 1'b1;
    end else if (eng_armed && !eng_done) begin
      eng_cnt <= eng_cnt + 1;
      if (eng_cnt + 1 == eng_delay) begin
        eng_done <= 1'b1; eng_accept <= eng_acc_val;
      end
    end
  end

  int c_we = 0, c_rd = 0, c_start = 0, c_rst = 0;
  always @(posedge clk) begin
    c_we    <= c_we    + (mem_we    ? 1 : 0);
    c_rd    <= c_rd    + (mem_rd_en ? 1 : 0);
    c_start <= c_start + (eng_start ? 1 : 0);
    c_rst   <= c_rst   + (eng_rst   ? 1 : 0);
  end

  int n_vec = 0, n_err = 0;

  // Reference model
  logic [31:0] m_last;
  logic        m_err, m_acc;
  logic [1:0]  m_code;
  logic [7:0]  m_op;
  logic [15:0] m_tag;
  logic [63:0] m_dout;
  logic [63:0] m_mem [0:1023];
  int e_we, e_rd, e_start, e_rst, e_lat;

  task automatic model_reset();
    m_last = 0; m_err = 0; m_acc = 0; m_code = 0; m_op = 0; m_tag = 0; m_dout = 0;
  endtask

  task automatic model_cmd(input logic [31:0] cmd, input logic [31:0] addr, input logic [63:0] data,
                           input logic [31:0] sp, input logic [31:0] ep, input int d, input logic acc);
    logic [7:0] op;
    e_we = 0; e_rd = 0; e_start = 0; e_rst = 0; e_lat = 0;
    if (cmd == m_last) return;
    m_last = cmd;
    op = cmd[7:0];
    if (m_err) begin
      if (op == 8'h05) begin m_err = 0; m_code = 0; m_op = op; m_tag = cmd[23:8]; end
      return;
    end
    m_op = op; m_tag = cmd[23:8];
    case (op)
      8'h00: ;
      8'h01: begin m_mem[addr % 1024] = data; e_we = 1; e_lat = 1; end
      8'h02: begin m_dout = m_mem[addr % 1024]; e_rd = 1; e_lat = RDL + 1; end
      8'h03: begin
        if (sp > ep) begin m_err = 1; m_code = 3; end
        else begin
          e_start = 1;
          if (d >= 1 && d < TO) begin m_dout = {62'b0, 1'b1, acc}; m_acc = acc; e_lat = d + 2; end
          else begin m_err = 1; m_code = 2; e_lat = TO + 1; end
        end
      end
      8'h04: begin e_rst = 4; e_lat = 4; end
      8'h05: begin m_err = 0; m_code = 0; end
      default: begin m_err = 1; m_code = 1; end
    endcase
  endtask

  function automatic logic [31:0] exp_status();
    return {m_tag, m_op, m_acc, m_code, m_err, 1'b0, (m_err ? 3'd6 : 3'd0)};
  endfunction

  // Driver: apply one command, then wait (bounded) until the controller is no longer busy.
  bit a_to;
  int a_lat;
  int sn_we, sn_rd, sn_start, sn_rst;
  task automatic apply_cmd(input logic [31:0] cmd, input logic [31:0] addr, input logic [63:0] data,
                           input logic [31:0] sp, input logic [31:0] ep, input int d, input logic acc);
    @(negedge clk);
    command = cmd; address = addr; data_in = data;
    start_cc_pointer = sp; end_cc_pointer = ep;
    eng_delay = d; eng_acc_val = acc;
    sn_we = c_we; sn_rd = c_rd; sn_start = c_start; sn_rst = c_rst;
    model_cmd(cmd, addr, data, sp, ep, d, acc);
    @(negedge clk);
    a_lat = 0;
    while (status[3] && a_lat < TO + 50) begin @(negedge clk); a_lat++; end
    a_to = status[3];
  endtask

  task automatic test_reset();
    rst_n = 1'b0; command = 0; address = 0; data_in = 0; start_cc_pointer = 0; end_cc_pointer = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    n_vec++; if (status !== 32'd0) begin n_err++; $display("FAIL reset_status got=%h exp=0", status); end
    n_vec++; if ({data_out, mem_we, mem_rd_en, mem_addr, mem_wdata, eng_rst, eng_start, eng_start_cc, eng_end_cc} !== '0) begin
      n_err++; $display("FAIL reset_outputs data_out=%h mem_we=%b eng_start=%b exp all zero", data_out, mem_we, eng_start);
    end
  endtask

  task automatic test_write();
    logic [63:0] wd;
    wd = 64'hDEAD_BEEF_0123_4567;
    @(negedge clk);
    command = 32'h0000_0101; address = 5; data_in = wd;
    sn_we = c_we;
    model_cmd(32'h0000_0101, 5, wd, 0, 0, 0, 0);
    @(negedge clk);
    n_vec++; if (mem_we !== 1'b1) begin n_err++; $display("FAIL wr_we_high got=%b exp=1", mem_we); end
    n_vec++; if (mem_addr !== 10'd5) begin n_err++; $display("FAIL wr_addr got=%0d exp=5", mem_addr); end
    n_vec++; if (mem_wdata !== wd) begin n_err++; $display("FAIL wr_wdata got=%h exp=%h", mem_wdata, wd); end
    @(negedge clk);
    n_vec++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL wr_we_low got=%b exp=0", mem_we); end
    n_vec++; if (c_we - sn_we !== 1) begin n_err++; $display("FAIL wr_pulses got=%0d exp=1", c_we - sn_we); end
    n_vec++; if (status !== 32'h0001_0100) begin n_err++; $display("FAIL wr_status got=%h exp=00010100", status); end
    n_vec++; if (dev_mem[5] !== wd) begin n_err++; $display("FAIL wr_mem got=%h exp=%h", dev_mem[5], wd); end
  endtask

  task automatic test_read();
    logic [63:0] old;
    old = m_dout;
    @(negedge clk);
    command = 32'h0000_0202; address = 5;
    sn_rd = c_rd;
    model_cmd(32'h0000_0202, 5, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_vec++; if (mem_rd_en !== 1'b1) begin n_err++; $display("FAIL rd_en_high got=%b exp=1", mem_rd_en); end
    @(negedge clk);
    n_vec++; if (mem_rd_en !== 1'b0) begin n_err++; $display("FAIL rd_en_low got=%b exp=0", mem_rd_en); end
    @(negedge clk);
    n_vec++; if (data_out !== old) begin n_err++; $display("FAIL rd_early got=%h exp=%h", data_out, old); end
    @(negedge clk);
    n_vec++; if (data_out !== 64'hDEAD_BEEF_0123_4567) begin n_err++; $display("FAIL rd_data got=%h exp=deadbeef01234567", data_out); end
    n_vec++; if (status !== exp_status()) begin n_err++; $display("FAIL rd_status got=%h exp=%h", status, exp_status()); end
    n_vec++; if (c_rd - sn_rd !== 1) begin n_err++; $display("FAIL rd_pulses got=%0d exp=1", c_rd - sn_rd); end
  endtask

  task automatic test_run();
    apply_cmd(32'h0000_0303, 0, 0, 0, 16, 50, 1'b1);
    n_vec++; if (a_to) begin n_err++; $display("FAIL run_wait got=busy exp=idle"); end
    n_vec++; if (c_start - sn_start !== 1) begin n_err++; $display("FAIL run_starts got=%0d exp=1", c_start - sn_start); end
    n_vec++; if (eng_start_cc !== 32'd0 || eng_end_cc !== 32'd16) begin n_err++; $display("FAIL run_cc got=%0d/%0d exp=0/16", eng_start_cc, eng_end_cc); end
    n_vec++; if (data_out !== 64'h3) begin n_err++; $display("FAIL run_dout got=%h exp=3", data_out); end
    n_vec++; if (status !== exp_status()) begin n_err++; $display("FAIL run_status got=%h exp=%h", status, exp_status()); end
    n_vec++; if (a_lat !== e_lat) begin n_err++; $display("FAIL run_latency got=%0d exp=%0d", a_lat, e_lat); end
    apply_cmd(32'h0000_0303, 0, 0, 0, 16, 50, 1'b1);
    repeat (5) @(negedge clk);
    n_vec++; if (c_start - sn_start !== 0) begin n_err++; $display("FAIL run_repeat got=%0d starts exp=0", c_start - sn_start); end
    n_vec++; if (status !== exp_status()) begin n_err++; $display("FAIL run_repeat_status got=%h exp=%h", status, exp_status()); end
  endtask

  task automatic test_timeout();
    apply_cmd(32'h0000_0403, 0, 0, 2, 9, 1000000, 1'b1);
    n_vec++; if (a_lat !== TO + 1) begin n_err++; $display("FAIL to_latency got=%0d exp=%0d", a_lat, TO + 1); end
    n_vec++; if (status[6:4] !== 3'b101 || status[2:0] !== 3'd6) begin n_err++; $display("FAIL to_error got=%h exp code2 err state6", status); end
    apply_cmd(32'h0000_0A04, 0, 0, 0, 0, 0, 1'b0);
    repeat (6) @(negedge clk);
    n_vec++; if (c_rst - sn_rst !== 0) begin n_err++; $display("FAIL to_absorb got=%0d rst pulses exp=0", c_rst - sn_rst); end
    n_vec++; if (status !== exp_status()) begin n_err++; $display("FAIL to_absorb_status got=%h exp=%h", status, exp_status()); end
    apply_cmd(32'h0000_0B05, 0, 0, 0, 0, 0, 1'b0);
    n_vec++; if (status[4] !== 1'b0 || status[2:0] !== 3'd0) begin n_err++; $display("FAIL to_clear got=%h exp idle no error", status); end
  endtask

  task automatic test_bad_cmds();
    apply_cmd(32'h0000_0C03, 0, 0, 20, 10, 5, 1'b1);
    n_vec++; if (status[6:5] !== 2'd3 || status[4] !== 1'b1) begin n_err++; $display("FAIL ptr_err got=%h exp code3", status); end
    n_vec++; if (c_start - sn_start !== 0) begin n_err++; $display("FAIL ptr_start got=%0d exp=0", c_start - sn_start); end
    apply_cmd(32'h0000_0D05, 0, 0, 0, 0, 0, 1'b0);
    apply_cmd(32'h0000_0E7F, 0, 0, 0, 0, 0, 1'b0);
    n_vec++; if (status !== exp_status() || status[6:5] !== 2'd1) begin n_err++; $display("FAIL illegal got=%h exp=%h", status, exp_status()); end
    apply_cmd(32'h0000_0F05, 0, 0, 0, 0, 0, 1'b0);
    n_vec++; if (status !== exp_status()) begin n_err++; $display("FAIL illegal_clr got=%h exp=%h", status, exp_status()); end
  endtask

  task automatic test_reset_mid_run();
    int sn;
    @(negedge clk);
    command = 32'h0000_1003; start_cc_pointer = 1; end_cc_pointer = 2;
    eng_delay = 20; eng_acc_val = 1'b1;
    sn = c_start;
    repeat (8) @(negedge clk);
    n_vec++; if (status[2:0] !== 3'd4) begin n_err++; $display("FAIL mid_wait got=%0d exp state 4", status[2:0]); end
    rst_n = 1'b0; command = 0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    n_vec++; if ({status, data_out, mem_we, mem_rd_en, mem_addr, mem_wdata, eng_rst, eng_start, eng_start_cc, eng_end_cc} !== '0) begin
      n_err++; $display("FAIL mid_reset status=%h data_out=%h exp all zero", status, data_out);
    end
    repeat (30) @(negedge clk);
    n_vec++; if (data_out !== 64'd0 || status !== 32'd0 || c_start - sn !== 1) begin
      n_err++; $display("FAIL mid_after data_out=%h status=%h starts=%0d exp 0/0/1", data_out, status, c_start - sn);
    end
    apply_cmd(32'h0000_1103, 0, 0, 0, 0, TO - 1, 1'b0);
    n_vec++; if (status !== exp_status() || data_out !== 64'h2) begin n_err++; $display("FAIL done_wins status=%h dout=%h exp %h/2", status, data_out, exp_status()); end
    apply_cmd(32'h0000_1203, 0, 0, 0, 0, TO, 1'b1);
    n_vec++; if (status !== exp_status() || status[6:5] !== 2'd2) begin n_err++; $display("FAIL just_late got=%h exp=%h", status, exp_status()); end
    apply_cmd(32'h0000_1305, 0, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic test_random();
    int wq[$];
    logic [31:0] cmd, prev, addr, sp, ep;
    logic [63:0] data;
    logic [7:0] op;
    logic acc;
    int d, r, tag;
    tag = 16'h100; prev = 32'h0000_1305;
    for (int it = 0; it < 120; it++) begin
      r = $urandom_range(0, 9);
      addr = $urandom; data = {$urandom, $urandom};
      sp = $urandom_range(0, 40); ep = $urandom_range(0, 40);
      d = ($urandom_range(0, 3) == 0) ? $urandom_range(TO - 2, TO + 2) : $urandom_range(1, 40);
      acc = 1'($urandom_range(0, 1));
      case (r)
        0: op = 8'h00;
        1, 2: op = 8'h01;
        3: op = (wq.size() > 0) ? 8'h02 : 8'h01;
        4, 5: op = 8'h03;
        6: op = 8'h04;
        7: op = 8'h05;
        default: op = 8'($urandom_range(6, 255));
      endcase
      if (op == 8'h02) addr = {$urandom, 10'd0} | 32'(wq[$urandom_range(0, wq.size() - 1)]);
      tag++;
      cmd = (r == 9) ? prev : {8'h00, tag[15:0], op};
      prev = cmd;
      apply_cmd(cmd, addr, data, sp, ep, d, acc);
      if (e_we == 1) wq.push_back(int'(addr[9:0]));
      n_vec++; if (a_to) begin n_err++; $display("FAIL rnd%0d_hang cmd=%h still busy", it, cmd); end
      n_vec++; if (status !== exp_status()) begin n_err++; $display("FAIL rnd%0d_status cmd=%h got=%h exp=%h", it, cmd, status, exp_status()); end
      n_vec++; if (data_out !== m_dout) begin n_err++; $display("FAIL rnd%0d_dout cmd=%h got=%h exp=%h", it, cmd, data_out, m_dout); end
      n_vec++; if (a_lat !== e_lat) begin n_err++; $display("FAIL rnd%0d_latency cmd=%h got=%0d exp=%0d", it, cmd, a_lat, e_lat); end
      n_vec++; if (c_we - sn_we !== e_we || c_rd - sn_rd !== e_rd || c_start - sn_start !== e_start || c_rst - sn_rst !== e_rst) begin
        n_err++; $display("FAIL rnd%0d_pulses cmd=%h got we%0d rd%0d st%0d rs%0d exp %0d %0d %0d %0d", it, cmd,
                          c_we - sn_we, c_rd - sn_rd, c_start - sn_start, c_rst - sn_rst, e_we, e_rd, e_start, e_rst);
      end
      if (e_we == 1) begin
        n_vec++; if (dev_mem[addr[9:0]] !== m_mem[addr[9:0]]) begin n_err++; $display("FAIL rnd%0d_mem got=%h exp=%h", it, dev_mem[addr[9:0]], m_mem[addr[9:0]]); end
      end
      if (e_start == 1) begin
        n_vec++; if (eng_start_cc !== sp || eng_end_cc !== ep) begin n_err++; $display("FAIL rnd%0d_cc got=%0d/%0d exp=%0d/%0d", it, eng_start_cc, eng_end_cc, sp, ep); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_run();
    test_timeout();
    test_bad_cmds();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
